// File: rtl/cpu_imm_pkg.sv
// Immediate-format codes shared by the immediate encoder and the decode-stage sign extender.
package cpu_imm_pkg;

  typedef logic [2:0] imm_sel_t;

  localparam imm_sel_t IMM_I    = 3'b000;
  localparam imm_sel_t IMM_S    = 3'b001;
  localparam imm_sel_t IMM_U    = 3'b010;
  localparam imm_sel_t IMM_B    = 3'b011;
  localparam imm_sel_t IMM_J    = 3'b100;
  localparam imm_sel_t IMM_LO12 = 3'b101;

  // True when value[31:msb] are all copies of one bit, i.e. it sign-extends from bit msb.
  function automatic logic fits_sext(input logic [31:0] value, input logic [4:0] msb);
    logic signed [31:0] shifted;
    shifted = $signed(value) >>> msb;
    return (&shifted) || (~|shifted);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational slicing of an immediate into its instruction bit positions, plus range check.
module imm_field_pack
  import cpu_imm_pkg::*;
(
  input  imm_sel_t    sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  // Fields not owned by the format keep the template bits; reserved codes always flag.
  always_comb begin
    instr = base;
    err   = 1'b0;
    case (sel)
      IMM_I: begin
        instr[31:20] = imm[11:0];
        err          = !fits_sext(imm, 5'd11);
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = !fits_sext(imm, 5'd11);
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
        err          = (imm[11:0] != 12'h000);
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        err          = !fits_sext(imm, 5'd12) || imm[0];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        err          = !fits_sext(imm, 5'd20) || imm[0];
      end
      IMM_LO12: begin
        instr[18:7] = imm[11:0];
        err         = !fits_sext(imm, 5'd11);
      end
      default: begin
        instr = base;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_field_pack with a saturating error counter.
module imm_encoder
  import cpu_imm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  select_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o
);

  logic [31:0] pack_instr_s;
  logic        pack_err_s;
  logic        s2_load_s;
  logic        s1_open_s;
  logic        out_fire_s;

  logic        s1_valid_r;
  logic [31:0] s1_instr_r;
  logic        s1_err_r;
  logic        valid_r;
  logic [31:0] instr_r;
  logic        err_r;
  logic [15:0] err_cnt_r;

  imm_field_pack u_pack (
    .sel   (select_i),
    .imm   (imm_i),
    .base  (base_i),
    .instr (pack_instr_s),
    .err   (pack_err_s)
  );

  assign s2_load_s  = !valid_r || ready_i;
  assign s1_open_s  = !s1_valid_r || s2_load_s;
  assign out_fire_s = valid_r && ready_i;
  // Reset gating keeps requests from being offered a handshake that reset would discard.
  assign ready_o    = !rst_i && s1_open_s;

  assign valid_o   = valid_r;
  assign instr_o   = instr_r;
  assign err_o     = err_r;
  assign err_cnt_o = err_cnt_r;

  // S1: capture the packed fields and range check of an accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_instr_r <= 32'h0000_0000;
      s1_err_r   <= 1'b0;
    end else if (s1_open_s) begin
      s1_valid_r <= valid_i;
      if (valid_i) begin
        s1_instr_r <= pack_instr_s;
        s1_err_r   <= pack_err_s;
      end
    end
  end

  // S2: output register, refilled when empty or being consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (s2_load_s) begin
      valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        instr_r <= s1_instr_r;
        err_r   <= s1_err_r;
      end
    end
  end

  // Count consumed errored results, holding at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_r <= 16'h0000;
    end else if (out_fire_s && err_r && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

endmodule
